sipo_rx: RTL

//  Serial-in/parallel-out receiver; the counterpart of the team's PISO transmitter at baud rate N.

---
 rtl/sipo_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx -- serial-in / parallel-out frame receiver
//
// Recovers framed words from a one-bit line driven by the matching PISO
// transmitter in the same clock domain. A frame is made of:
//   * a start bit (0)
//   * WIDTH data bits, LSB first
//   * a stop bit (1)
// The line idles high, and every bit is held for N clocks.
//
// All sampling is anchored to E0, the first edge that sees the line low.
//   * The start bit is re-checked at E0 + N/2.
//   * Every later bit is sampled N clocks after the previous one, which puts
//     each sample close to the middle of its bit.
//
// Parameters
//   N      clocks per bit, N >= 2
//   WIDTH  data bits per frame, WIDTH >= 2
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   din        in   1      serial line, idles high
//   dout       out  WIDTH  last correctly framed word, held between frames
//   valid      out  1      one-cycle pulse, dout was updated this cycle
//   frame_err  out  1      one-cycle pulse, the stop bit was sampled low
//   busy       out  1      high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module sipo_rx #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Counter values at which a sample is taken.
    // cnt is cleared on the edge that enters a state, so on the k-th edge after
    // that it holds k-1.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(N / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [WIDTH-1:0] dout_q,      dout_d;
    logic             valid_q,     valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q,      busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!din) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_HALF) begin
                    // Mid start bit. A line that is already high again was a
                    // glitch and is dropped silently.
                    cnt_d = '0;
                    if (din) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end

            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Data arrives LSB first. Entering at the MSB and shifting
                    // right leaves bit 0 in the LSB once all bits are in.
                    shift_d = {din, shift_q[WIDTH-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (din) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        // Going straight back to IDLE lets a start bit that
                        // immediately follows the stop bit still be caught.
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HI;
                    end
                end
            end

            WAIT_HI: begin
                // A line held low after a bad stop bit is a break, not a new
                // start bit. Wait for it to go high before rearming.
                if (din) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered from the next state, so busy_q always equals
        // (state_q != IDLE).
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
